// File: rtl/instr_mem_pkg.sv
// ============================================================================
// Module : instr_mem_pkg
// Brief  : Shared state encoding and default sizing for the instruction memory.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package instr_mem_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DEPTH  = 128;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_LOADING = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/instr_mem_sync_array.sv
// ============================================================================
// Module : instr_mem_array
// Brief  : DATA_W x DEPTH storage, one synchronous write port, registered read.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_mem_array #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 128,
    parameter int IDX_W  = 7
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // No reset on storage or read register; the caller masks stale read data.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/instr_mem_sync.sv
// ============================================================================
// Module : instr_mem_sync
// Brief  : Loadable instruction memory with streamed program load and 1-cycle fetch.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_mem_sync
    import instr_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_err,
    output logic [ADDR_W:0]   prog_len,
    output logic              ready
);

    localparam int            C_IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] C_LAST_IDX = (ADDR_W+1)'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W:0]   prog_len_q, prog_len_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic              fetch_err_q, fetch_err_d;
    logic              data_zero_q, data_zero_d;
    logic              w_we;
    logic              w_fetch_ok;
    logic [DATA_W-1:0] w_rdata;

    // The program length doubles as the write pointer: both count accepted words.
    always_comb begin
        state_d    = state_q;
        prog_len_d = prog_len_q;
        w_we       = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (load_start) begin
                    state_d    = ST_LOADING;
                    prog_len_d = '0;
                end
            end
            ST_LOADING: begin
                if (load_start) begin
                    prog_len_d = '0;
                end else if (load_valid) begin
                    w_we       = 1'b1;
                    prog_len_d = prog_len_q + 1'b1;
                    if (load_last || (prog_len_q == C_LAST_IDX)) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (load_start) begin
                    state_d    = ST_LOADING;
                    prog_len_d = '0;
                end
            end
            default: begin
                state_d    = ST_EMPTY;
                prog_len_d = '0;
            end
        endcase
    end

    assign w_fetch_ok = fetch_en && (state_q == ST_RUN) &&
                        ({1'b0, fetch_addr} < prog_len_q);

    // data_zero forces fetch_data to 0 after reset or a reject, and holds otherwise.
    always_comb begin
        fetch_valid_d = w_fetch_ok;
        fetch_err_d   = fetch_en && !w_fetch_ok;
        data_zero_d   = fetch_en ? !w_fetch_ok : data_zero_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_EMPTY;
            prog_len_q    <= '0;
            fetch_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
            data_zero_q   <= 1'b1;
        end else begin
            state_q       <= state_d;
            prog_len_q    <= prog_len_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_err_q   <= fetch_err_d;
            data_zero_q   <= data_zero_d;
        end
    end

    instr_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (C_IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (w_we && !reset),
        .waddr (prog_len_q[C_IDX_W-1:0]),
        .wdata (load_data),
        .re    (w_fetch_ok && !reset),
        .raddr (fetch_addr[C_IDX_W-1:0]),
        .rdata (w_rdata)
    );

    assign load_ready  = (state_q == ST_LOADING);
    assign ready       = (state_q == ST_RUN);
    assign prog_len    = prog_len_q;
    assign fetch_valid = fetch_valid_q;
    assign fetch_err   = fetch_err_q;
    assign fetch_data  = data_zero_q ? '0 : w_rdata;

endmodule

`default_nettype wire

// File: doc/instr_mem_sync.md
INSTR_MEM_SYNC -- requirements
Module: instr_mem_sync

Interface
REQ-001 SHALL have parameter DATA_W, 8, instruction word width in bits.
REQ-002 SHALL have parameter ADDR_W, 8, fetch address width in bits.
REQ-003 SHALL have parameter DEPTH, 128, words stored; DEPTH <= 2**ADDR_W.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port load_start  input  1  begin a program load at word 0.
REQ-007 SHALL have port load_valid  input  1  load_data valid this cycle.
REQ-008 SHALL have port load_data  input  DATA_W  word to write.
REQ-009 SHALL have port load_last  input  1  marks final word of a load.
REQ-010 SHALL have port load_ready  output  1  loader accepts a word this cycle.
REQ-011 SHALL have port fetch_en  input  1  fetch request.
REQ-012 SHALL have port fetch_addr  input  ADDR_W  fetch word address.
REQ-013 SHALL have port fetch_valid  output  1  fetch_data valid.
REQ-014 SHALL have port fetch_data  output  DATA_W  fetched word.
REQ-015 SHALL have port fetch_err  output  1  fetch request rejected.
REQ-016 SHALL have port prog_len  output  ADDR_W+1  words in current program.
REQ-017 SHALL have port ready  output  1  program loaded, fetch enabled.

Function
REQ-018 SHALL implement states EMPTY, LOADING, RUN.
REQ-019 SHALL go EMPTY->LOADING and RUN->LOADING on load_start; a load_start seen in LOADING restarts the load.
REQ-020 SHALL go LOADING->RUN on an accepted word with load_last=1, or on the accepted word at write pointer DEPTH-1 (auto-terminate).
REQ-021 SHALL, on load_start, set write pointer and prog_len to 0 next cycle; load_start beats same-cycle load_valid, whose word is dropped.
REQ-022 SHALL drive load_ready=1 only in LOADING, decoded from state.
REQ-023 SHALL accept a word when load_valid && load_ready: mem[wptr]<=load_data, wptr+1, prog_len+1, all in the same edge.
REQ-024 SHALL ignore load_valid outside LOADING (no write, no count change).
REQ-025 SHALL give fetch latency 1: fetch_en at edge N, response on outputs after edge N+1, one-cycle pulse; one request per cycle accepted, back-to-back allowed.
REQ-026 SHALL service a fetch when state==RUN and fetch_addr < prog_len: fetch_valid=1, fetch_err=0, fetch_data=mem[fetch_addr].
REQ-027 SHALL reject any other fetch_en: fetch_valid=0, fetch_err=1, fetch_data=0 for one cycle.
REQ-028 SHALL drive fetch_valid=0, fetch_err=0 with no fetch_en; fetch_data holds last value.
REQ-029 SHALL service a fetch coincident with load_start in RUN using pre-load contents (state still RUN that cycle).
REQ-030 SHALL drive ready=1 iff state==RUN.

Reset
REQ-031 SHALL, on reset, enter EMPTY with wptr=0, prog_len=0, fetch_valid=0, fetch_err=0, fetch_data=0, load_ready=0, ready=0.
REQ-032 SHALL give reset priority over load_start, load_valid and fetch_en.
REQ-033 SHALL leave memory contents untouched by reset; reset mid-load abandons the load, prior words unreadable (prog_len=0).

Structure
REQ-034 SHALL place the state enumeration and default parameter values in shared package instr_mem_pkg.
REQ-035 SHALL instantiate sub-module instr_mem_array: DATA_W x DEPTH, one synchronous write port, one registered read port.

Verification
REQ-036 SHALL test: reset, fetch_en addr 0 -> next cycle fetch_err=1, fetch_valid=0.
REQ-037 SHALL test: load_start, words 2,3,2,3 (load_last on 4th) -> ready=1, prog_len=4; fetch 0..3 -> 2,3,2,3 one cycle later; fetch 4 -> fetch_err=1.
REQ-038 SHALL test: load 128 words without load_last -> RUN after word 127, prog_len=128, load_ready=0, 129th load_valid ignored.
REQ-039 SHALL test: load_start with load_valid same cycle -> word dropped, prog_len=0; gapped load_valid counts only valid cycles.
REQ-040 SHALL test: reset after 2 of 4 words -> EMPTY, prog_len=0, fetch addr 0 -> fetch_err=1.
REQ-041 SHALL test: in RUN with prog_len=4, reload 7,9 (last) -> prog_len=2, fetch 1 -> 9, fetch 3 -> fetch_err=1.
